// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and helpers for the multi-port register file
package regfile_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_NREGS  = 32;

    // Modules build their own address/data types from these widths:
    //   typedef logic [$clog2(NREGS)-1:0] reg_addr_t;
    //   typedef logic [DATA_W-1:0]        reg_data_t;

    // Value a register takes while reset is asserted: its own index, or 0 for the hard-zero register.
    function automatic int reset_value(input int i, input int zero_reg);
        return (i == zero_reg) ? 0 : i;
    endfunction

    // True when the address names the hard-zero register; zero_reg >= nregs disables it.
    function automatic logic is_zero_reg(input int addr, input int zero_reg, input int nregs);
        return (zero_reg < nregs) && (addr == zero_reg);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/reserve port bundle of the multi-port register file
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = 2,
    parameter int NWR    = 1
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = AW + 1;

    logic [NRD-1:0][AW-1:0]     ra;
    logic [NRD-1:0][DATA_W-1:0] rd;
    logic [NRD-1:0]             rd_pend;
    logic [NWR-1:0]             we;
    logic [NWR-1:0][AW-1:0]     wa;
    logic [NWR-1:0][DATA_W-1:0] wd;
    logic                       rsv_en;
    logic [AW-1:0]              rsv_addr;
    logic [CW-1:0]              pend_cnt;

    modport master (
        output ra, we, wa, wd, rsv_en, rsv_addr,
        input  rd, rd_pend, pend_cnt
    );

    modport slave (
        input  ra, we, wa, wd, rsv_en, rsv_addr,
        output rd, rd_pend, pend_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits, hazard flags and pending count
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = AW + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NRD-1:0][AW-1:0] ra,
    input  logic [NWR-1:0]         we,
    input  logic [NWR-1:0][AW-1:0] wa,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    output logic [NRD-1:0]         rd_pend,
    output logic [CW-1:0]          pend_cnt
);

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [NWR-1:0]   clr_en;
    logic             set_en;
    logic [NRD-1:0]   byp_hit;
    logic [NRD-1:0]   rsv_hit;

    // Writes and reservations aimed at the hard-zero register have no effect on the bits.
    always_comb begin
        clr_en = '0;
        for (int k = 0; k < NWR; k++) begin
            clr_en[k] = we[k] && !is_zero_reg(int'(wa[k]), ZERO_REG, NREGS);
        end
        set_en = rsv_en && !is_zero_reg(int'(rsv_addr), ZERO_REG, NREGS);
    end

    // Next pending vector: writes clear, a reservation on the same edge sets and wins.
    always_comb begin
        pend_nxt = pend;
        for (int k = 0; k < NWR; k++) begin
            if (clr_en[k]) pend_nxt[wa[k]] = 1'b0;
        end
        if (set_en) pend_nxt[rsv_addr] = 1'b1;
    end

    // Count adjusts by one per bit that rises and one per bit that falls this edge.
    always_comb begin
        cnt_nxt = pend_cnt;
        for (int i = 0; i < NREGS; i++) begin
            if (pend_nxt[i] && !pend[i]) cnt_nxt = cnt_nxt + CW'(1);
            else if (!pend_nxt[i] && pend[i]) cnt_nxt = cnt_nxt - CW'(1);
        end
    end

    // Pending bits and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // Hazard flag per read port; a forwarded write hides the hazard unless it is re-reserved now.
    always_comb begin
        byp_hit = '0;
        rsv_hit = '0;
        rd_pend = '0;
        for (int j = 0; j < NRD; j++) begin
            for (int k = 0; k < NWR; k++) begin
                if (clr_en[k] && (wa[k] == ra[j])) byp_hit[j] = 1'b1;
            end
            rsv_hit[j] = set_en && (rsv_addr == ra[j]);
            rd_pend[j] = pend[ra[j]] && !is_zero_reg(int'(ra[j]), ZERO_REG, NREGS)
                         && !((BYPASS != 0) && byp_hit[j] && !rsv_hit[j]);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with bypass and pending scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    typedef logic [AW-1:0]     reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    reg_data_t      mem [NREGS];
    logic [NWR-1:0] we_eff;

    // Drop writes to the hard-zero register before they reach storage or the bypass.
    always_comb begin
        we_eff = '0;
        for (int k = 0; k < NWR; k++) begin
            we_eff[k] = bus.we[k] && !is_zero_reg(int'(bus.wa[k]), ZERO_REG, NREGS);
        end
    end

    // Storage; higher-numbered ports are applied last so port 1 wins an address conflict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= reg_data_t'(reset_value(i, ZERO_REG));
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we_eff[k]) mem[reg_addr_t'(bus.wa[k])] <= bus.wd[k];
            end
        end
    end

    // Combinational read with optional same-cycle forwarding, port 1 taking priority.
    always_comb begin
        bus.rd = '0;
        for (int j = 0; j < NRD; j++) begin
            bus.rd[j] = mem[reg_addr_t'(bus.ra[j])];
            if (BYPASS != 0) begin
                for (int k = 0; k < NWR; k++) begin
                    if (we_eff[k] && (bus.wa[k] == bus.ra[j])) bus.rd[j] = bus.wd[k];
                end
            end
            if (is_zero_reg(int'(bus.ra[j]), ZERO_REG, NREGS)) bus.rd[j] = '0;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .ra       (bus.ra),
        .we       (bus.we),
        .wa       (bus.wa),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .rd_pend  (bus.rd_pend),
        .pend_cnt (bus.pend_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(64), .NREGS(32), .NRD(2), .NWR(2)) bus ();
    regfile_mp_if #(.DATA_W(64), .NREGS(32), .NRD(2), .NWR(1)) bus_nb ();

    regfile_mp #(
        .DATA_W(64), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(31), .BYPASS(1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    regfile_mp #(
        .DATA_W(64), .NREGS(32), .NRD(2), .NWR(1), .ZERO_REG(31), .BYPASS(0)
    ) dut_nb (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_nb.slave)
    );

    logic [63:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : {64{1'bz}};
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ra = '0; bus.we = '0; bus.wa = '0; bus.wd = '0;
        bus.rsv_en = 1'b0; bus.rsv_addr = '0;
        bus_nb.ra = '0; bus_nb.we = '0; bus_nb.wa = '0; bus_nb.wd = '0;
        bus_nb.rsv_en = 1'b0; bus_nb.rsv_addr = '0;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #2;
        bus.ra[0] = 5'd5;
        push(64'd5);
        #1 check("in_reset_rd", bus.rd[0]);
        bus.ra[0] = 5'd0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // reset contents on both read ports, no pending state
        for (int i = 0; i < 32; i++) begin
            bus.ra[0] = 5'(i);
            bus.ra[1] = 5'(31 - i);
            push((i == 31) ? 64'd0 : 64'(i));
            push((i == 0) ? 64'd0 : 64'(31 - i));
            push(64'd0);
            #1;
            check("reset_rd0", bus.rd[0]);
            check("reset_rd1", bus.rd[1]);
            check("reset_pend", 64'(bus.rd_pend));
        end
        push(64'd0);
        check("reset_cnt", 64'(bus.pend_cnt));

        // write/readback, plus hard-zero discard
        bus.we = 2'b01; bus.wa[0] = 5'd5; bus.wd[0] = 64'hDEADBEEF_DEADBEEF;
        bus_nb.we = 1'b1; bus_nb.wa[0] = 5'd5; bus_nb.wd[0] = 64'hDEADBEEF_DEADBEEF;
        push(64'hDEADBEEF_DEADBEEF);
        push(64'hDEADBEEF_DEADBEEF);
        tick();
        idle();
        bus.ra[0] = 5'd5; bus_nb.ra[0] = 5'd5;
        #1;
        check("wr_x5", bus.rd[0]);
        check("wr_x5_nb", bus_nb.rd[0]);
        bus.we = 2'b01; bus.wa[0] = 5'd31; bus.wd[0] = 64'h1234; bus.ra[0] = 5'd31;
        push(64'd0);
        #1 check("wr_x31_byp", bus.rd[0]);
        tick();
        idle();
        bus.ra[0] = 5'd31;
        push(64'd0);
        #1 check("wr_x31_rd", bus.rd[0]);

        // same-cycle forwarding on bypass vs non-bypass instance
        bus.we = 2'b01; bus.wa[0] = 5'd7; bus.wd[0] = 64'hAA; bus.ra[1] = 5'd7;
        bus_nb.we = 1'b1; bus_nb.wa[0] = 5'd7; bus_nb.wd[0] = 64'hAA; bus_nb.ra[1] = 5'd7;
        push(64'hAA);
        push(64'd7);
        #1;
        check("byp_on", bus.rd[1]);
        check("byp_off", bus_nb.rd[1]);
        tick();
        idle();
        bus_nb.ra[1] = 5'd7;
        push(64'hAA);
        #1 check("byp_off_after", bus_nb.rd[1]);

        // dual-write conflict: port 1 wins, both in bypass and in storage
        bus.we = 2'b11; bus.wa[0] = 5'd9; bus.wa[1] = 5'd9;
        bus.wd[0] = 64'h11; bus.wd[1] = 64'h22; bus.ra[0] = 5'd9;
        push(64'h22);
        #1 check("dual_byp", bus.rd[0]);
        tick();
        idle();
        bus.ra[0] = 5'd9;
        push(64'h22);
        #1 check("dual_store", bus.rd[0]);

        // reserve X3
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        tick();
        idle();
        bus.ra[0] = 5'd3;
        push(64'd1);
        push(64'd1);
        #1;
        check("rsv_pend", 64'(bus.rd_pend[0]));
        check("rsv_cnt", 64'(bus.pend_cnt));

        // write X3 hides the hazard this cycle and clears it at the edge
        bus.we = 2'b01; bus.wa[0] = 5'd3; bus.wd[0] = 64'h33;
        push(64'd0);
        push(64'h33);
        #1;
        check("wr_clr_pend_byp", 64'(bus.rd_pend[0]));
        check("wr_clr_rd_byp", bus.rd[0]);
        tick();
        idle();
        bus.ra[0] = 5'd3;
        push(64'd0);
        push(64'd0);
        #1;
        check("wr_clr_cnt", 64'(bus.pend_cnt));
        check("wr_clr_pend", 64'(bus.rd_pend[0]));

        // reserve and write X3 on the same edge: reservation wins, data stored
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        bus.we = 2'b01; bus.wa[0] = 5'd3; bus.wd[0] = 64'h44;
        tick();
        idle();
        bus.ra[0] = 5'd3;
        push(64'd1);
        push(64'd1);
        push(64'h44);
        #1;
        check("rsvwr_pend", 64'(bus.rd_pend[0]));
        check("rsvwr_cnt", 64'(bus.pend_cnt));
        check("rsvwr_rd", bus.rd[0]);

        // reserving the hard-zero register changes nothing
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd31;
        tick();
        idle();
        bus.ra[1] = 5'd31;
        push(64'd1);
        push(64'd0);
        #1;
        check("rsv31_cnt", 64'(bus.pend_cnt));
        check("rsv31_pend", 64'(bus.rd_pend[1]));

        // X3 pending, written and re-reserved in one cycle: hazard stays visible
        bus.ra[0] = 5'd3;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        bus.we = 2'b10; bus.wa[1] = 5'd3; bus.wd[1] = 64'h55;
        push(64'd1);
        push(64'h55);
        #1;
        check("rersv_pend", 64'(bus.rd_pend[0]));
        check("rersv_rd", bus.rd[0]);
        tick();
        idle();
        push(64'd1);
        #1 check("rersv_cnt", 64'(bus.pend_cnt));

        // reserve X4 while writing X5 = 0xFF on port 1
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
        bus.we = 2'b10; bus.wa[1] = 5'd5; bus.wd[1] = 64'hFF;
        tick();
        idle();
        bus.ra[0] = 5'd5; bus.ra[1] = 5'd3;
        push(64'hFF);
        push(64'd1);
        push(64'd2);
        #1;
        check("pre_rst_rd", bus.rd[0]);
        check("pre_rst_pend", 64'(bus.rd_pend[1]));
        check("pre_rst_cnt", 64'(bus.pend_cnt));

        // asynchronous reset between edges
        #2 reset_n = 1'b0;
        push(64'd5);
        push(64'd0);
        push(64'd0);
        #1;
        check("mid_rst_rd", bus.rd[0]);
        check("mid_rst_pend", 64'(bus.rd_pend));
        check("mid_rst_cnt", 64'(bus.pend_cnt));
        bus.ra[1] = 5'd4;
        push(64'd0);
        #1 check("mid_rst_pend4", 64'(bus.rd_pend[1]));

        tick();
        n_total++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL queue_drained observed=%0d expected=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
